// File: rtl/bias_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bias_sequencer_pkg
// Purpose : Shared definitions for the bias-add sequencer: FSM state encoding
//           and the lane width used to size every vector bus.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package bias_sequencer_pkg;

   localparam int LANE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/bias_sequencer_seq_fifo.sv
// -----------------------------------------------------------------------------
// seq_fifo
// Purpose : Synchronous FIFO holding {last, data} results from the bias adder.
//           Push while full is honoured only together with a pop; pop while
//           empty is ignored. Pointers wrap modulo DEPTH (power of two).
// Ports   : clock, reset      - clock, asynchronous active-high reset
//           push, push_data   - write request and entry
//           pop,  pop_data    - read request and current head entry
//           empty             - no entries stored
//           count             - number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module seq_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_wr;
   logic             w_rd;

   assign w_full = (r_count == CNT_W'(DEPTH));
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign w_wr   = push & (~w_full | pop);
   assign w_rd   = pop & ~empty;

   // NOTE: storage carries no reset; only pointers and count are reset, so an
   // emptied FIFO never presents its stale contents as valid.
   always_ff @(posedge clock) begin
      if (w_wr) r_mem[r_wr_ptr] <= push_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
         else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
      end
   end

   assign pop_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/bias_sequencer.sv
// -----------------------------------------------------------------------------
// bias_sequencer
// Purpose : Sequences one layer's bias-add pass. Accepts activation vectors,
//           addresses the per-channel bias memory, presents aligned operands
//           to the external adder, tracks the adder pipeline with valid/last
//           tags and buffers results in an output FIFO.
// Ports   : clock, reset                  - clock, async active-high reset
//           cfg_start/num_ch/pix_per_ch   - pass start pulse and counts
//           busy, done, cfg_err           - pass status
//           in_valid/in_ready/in_data     - activation stream
//           bias_rd_addr/bias_rd_data     - bias memory (1-cycle read)
//           add_a, add_b, add_sum         - external lane adder
//           out_valid/out_ready/out_data/out_last - result stream
// -----------------------------------------------------------------------------
module bias_sequencer
   import bias_sequencer_pkg::*;
#(
   parameter int SIZE       = 4,
   parameter int CH_W       = 4,
   parameter int PIX_W      = 8,
   parameter int ADD_LAT    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cfg_start,
   input  logic [CH_W-1:0]          cfg_num_ch,
   input  logic [PIX_W-1:0]         cfg_pix_per_ch,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANE_W*SIZE-1:0]   in_data,
   output logic [CH_W-1:0]          bias_rd_addr,
   input  logic [LANE_W*SIZE-1:0]   bias_rd_data,
   output logic [LANE_W*SIZE-1:0]   add_a,
   output logic [LANE_W*SIZE-1:0]   add_b,
   input  logic [LANE_W*SIZE-1:0]   add_sum,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANE_W*SIZE-1:0]   out_data,
   output logic                     out_last
);

   localparam int DW    = LANE_W * SIZE;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   state_t             r_state;
   state_t             w_next;
   logic [CH_W-1:0]    r_num_ch;
   logic [CH_W-1:0]    r_ch_cnt;
   logic [PIX_W-1:0]   r_pix_per_ch;
   logic [PIX_W-1:0]   r_pix_cnt;
   logic [DW-1:0]      r_add_a;
   logic [ADD_LAT:0]   r_tag_v;
   logic [ADD_LAT:0]   r_tag_l;
   logic [CNT_W-1:0]   r_inflight;
   logic               r_cfg_err;

   logic [CNT_W-1:0]   w_fifo_count;
   logic               w_fifo_empty;
   logic [DW:0]        w_head;
   logic               w_cfg_zero;
   logic               w_start_ok;
   logic               w_pix_wrap;
   logic               w_last_vec;
   logic               w_credit;
   logic               w_accept;
   logic               w_push;
   logic               w_pop;
   logic               w_drain_done;

   assign w_cfg_zero = (cfg_num_ch == '0) | (cfg_pix_per_ch == '0);
   assign w_start_ok = (r_state == ST_IDLE) & cfg_start & ~w_cfg_zero;
   assign w_pix_wrap = (r_pix_cnt == r_pix_per_ch - PIX_W'(1));
   assign w_last_vec = w_pix_wrap & (r_ch_cnt == r_num_ch - CH_W'(1));

   // Credit covers both adder stages and FIFO slots, so every tagged sum has
   // a guaranteed slot when it emerges from the adder.
   assign w_credit = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);

   assign w_accept = in_valid & in_ready;
   assign w_push   = r_tag_v[ADD_LAT];
   assign w_pop    = out_ready & out_valid;

   // Finish as soon as the last entry leaves, including the cycle it pops.
   assign w_drain_done = (r_inflight == '0) &
                         (w_fifo_empty | ((w_fifo_count == CNT_W'(1)) & w_pop));

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // NOTE: w_next defaults to the current state so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_ok)              w_next = ST_RUN;
         ST_RUN:   if (w_accept && w_last_vec)  w_next = ST_DRAIN;
         ST_DRAIN: if (w_drain_done)            w_next = ST_DONE;
         ST_DONE:                               w_next = ST_IDLE;
         default:                               w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state != ST_IDLE);
      done     = (r_state == ST_DONE);
      in_ready = (r_state == ST_RUN) & w_credit;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_num_ch     <= '0;
         r_pix_per_ch <= '0;
         r_ch_cnt     <= '0;
         r_pix_cnt    <= '0;
         r_add_a      <= '0;
         r_tag_v      <= '0;
         r_tag_l      <= '0;
         r_inflight   <= '0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_cfg_err <= (r_state == ST_IDLE) & cfg_start & w_cfg_zero;

         if (w_start_ok) begin
            r_num_ch     <= cfg_num_ch;
            r_pix_per_ch <= cfg_pix_per_ch;
            r_ch_cnt     <= '0;
            r_pix_cnt    <= '0;
         end

         if (w_accept) begin
            r_add_a <= in_data;
            if (w_pix_wrap) begin
               r_pix_cnt <= '0;
               r_ch_cnt  <= r_ch_cnt + CH_W'(1);
            end else begin
               r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            end
         end

         // Tag stage 0 lines up with the operands; stage ADD_LAT with add_sum.
         r_tag_v[0] <= w_accept;
         r_tag_l[0] <= w_accept & w_last_vec;
         for (int i = 1; i <= ADD_LAT; i++) begin
            r_tag_v[i] <= r_tag_v[i-1];
            r_tag_l[i] <= r_tag_l[i-1];
         end

         if (w_accept && !w_push)      r_inflight <= r_inflight + CNT_W'(1);
         else if (!w_accept && w_push) r_inflight <= r_inflight - CNT_W'(1);
      end
   end

   seq_fifo #(
      .WIDTH (DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push),
      .push_data ({r_tag_l[ADD_LAT], add_sum}),
      .pop       (w_pop),
      .pop_data  (w_head),
      .empty     (w_fifo_empty),
      .count     (w_fifo_count)
   );

   assign cfg_err      = r_cfg_err;
   assign bias_rd_addr = r_ch_cnt;
   assign add_a        = r_add_a;
   assign add_b        = bias_rd_data;
   assign out_valid    = ~w_fifo_empty;
   assign out_data     = w_head[DW-1:0];
   // Head memory is not reset, so the last flag is qualified by non-empty.
   assign out_last     = w_head[DW] & ~w_fifo_empty;

endmodule
